// File: rtl/profiler_pkg.sv
// profiler_pkg: frame layout, counter ordering and shared types for the cache report serializer.
package profiler_pkg;
  localparam int FRAME_LEN = 36;
  localparam int NUM_CNT = 8;
  localparam logic [5:0] IDX_SEQ = 6'd2;
  localparam logic [5:0] IDX_PAYLOAD = 6'd3;
  localparam logic [5:0] IDX_CSUM = 6'(FRAME_LEN - 1);
  localparam int ORD_IC_REQ = 0;
  localparam int ORD_IC_HIT = 1;
  localparam int ORD_IC_MISS = 2;
  localparam int ORD_IC_FILL = 3;
  localparam int ORD_DC_REQ = 4;
  localparam int ORD_DC_HIT = 5;
  localparam int ORD_DC_MISS = 6;
  localparam int ORD_DC_FILL = 7;
  typedef enum logic {IDLE, SEND} report_state_t;
  typedef logic [31:0] counter_t;
  typedef logic [NUM_CNT-1:0][31:0] snapshot_t;
  // First-sent counter sits in the top slot so the payload drains by shifting left.
  function automatic int slot(input int ord);
    return NUM_CNT - 1 - ord;
  endfunction
endpackage

// File: rtl/profiler_period_timer.sv
// profiler_period_timer: free-running period counter giving a one-cycle tick every REPORT_PERIOD cycles.
module profiler_period_timer #(
  parameter int unsigned REPORT_PERIOD = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic tick_o
);
  localparam int W = REPORT_PERIOD > 1 ? $clog2(REPORT_PERIOD) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  logic run;
  assign run = enable_i && (REPORT_PERIOD != 0);
  assign tick_o = run && (cnt_q == W'(REPORT_PERIOD - 1));
  assign cnt_d = (!run || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cache_report_serializer.sv
// cache_report_serializer: snapshots eight profiler counters on a trigger and streams them as a framed byte packet.
module cache_report_serializer
  import profiler_pkg::*;
#(
  parameter int unsigned REPORT_PERIOD = 2000000,
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        report_req,
  input  logic [31:0] icache_hit_cnt,
  input  logic [31:0] icache_miss_cnt,
  input  logic [31:0] icache_request_cnt,
  input  logic [31:0] dcache_hit_cnt,
  input  logic [31:0] dcache_miss_cnt,
  input  logic [31:0] dcache_request_cnt,
  input  logic [31:0] icache_fill_lat_cnt,
  input  logic [31:0] dcache_fill_lat_cnt,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  frame_seq,
  output logic [7:0]  dropped_cnt
);
  report_state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] acc_q, acc_d, seq_q, seq_d, drop_q, drop_d;
  snapshot_t snap_q, snap_d, cap;
  logic tick, trig, xfer;
  profiler_period_timer #(.REPORT_PERIOD(REPORT_PERIOD)) u_timer (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .tick_o(tick)
  );
  assign cap[slot(ORD_IC_REQ)] = icache_request_cnt;
  assign cap[slot(ORD_IC_HIT)] = icache_hit_cnt;
  assign cap[slot(ORD_IC_MISS)] = icache_miss_cnt;
  assign cap[slot(ORD_IC_FILL)] = icache_fill_lat_cnt;
  assign cap[slot(ORD_DC_REQ)] = dcache_request_cnt;
  assign cap[slot(ORD_DC_HIT)] = dcache_hit_cnt;
  assign cap[slot(ORD_DC_MISS)] = dcache_miss_cnt;
  assign cap[slot(ORD_DC_FILL)] = dcache_fill_lat_cnt;
  assign tx_valid = state_q == SEND;
  assign busy = state_q == SEND;
  assign frame_seq = seq_q;
  assign dropped_cnt = drop_q;
  always_comb begin
    trig = enable && (tick || report_req);
    xfer = (state_q == SEND) && tx_ready;
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    snap_d = snap_q;
    seq_d = seq_q;
    drop_d = drop_q;
    tx_data = state_q == IDLE ? 8'h00 :
              idx_q == 6'd0 ? SYNC0 :
              idx_q == 6'd1 ? SYNC1 :
              idx_q == IDX_SEQ ? seq_q + 8'd1 :
              idx_q == IDX_CSUM ? acc_q : snap_q[NUM_CNT-1][31:24];
    if (state_q == IDLE) begin
      if (trig) begin
        state_d = SEND;
        idx_d = '0;
        acc_d = '0;
        snap_d = cap;
      end
    end else begin
      if (trig && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      if (xfer) begin
        idx_d = idx_q + 6'd1;
        if (idx_q >= IDX_SEQ && idx_q < IDX_CSUM) acc_d = acc_q + tx_data;
        if (idx_q >= IDX_PAYLOAD && idx_q < IDX_CSUM) snap_d = snap_q << 8;
        if (idx_q == IDX_CSUM) begin
          state_d = IDLE;
          seq_d = seq_q + 8'd1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      snap_q <= '0;
      seq_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      snap_q <= snap_d;
      seq_q <= seq_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_cache_report_serializer.sv
// tb_cache_report_serializer: scoreboard bench for the counter report framer, manual and periodic triggers.
module tb_cache_report_serializer;
  import profiler_pkg::*;
  typedef struct packed {
    logic [7:0][31:0] cnt;
    logic rnd;
    logic scr;
    logic [7:0] csum;
  } vec_t;
  logic clk = 0, rst_n = 0, enable = 0, report_req = 0, tx_ready = 1, enable_p = 0;
  logic [7:0][31:0] cnt = '0;
  logic [7:0] tx_data, frame_seq, dropped_cnt, tx_data_p, frame_seq_p, dropped_cnt_p;
  logic tx_valid, busy, tx_valid_p, busy_p;
  int total = 0, bad = 0, nx = 0, model_seq = 0, mode = 0, nx0 = 0;
  logic scramble = 0, stall_prev = 0;
  logic [7:0] stall_data = 0, last_byte = 0;
  logic [7:0] sbq[$];
  vec_t tbl[6];
  logic [7:0][31:0] c;
  always #5 clk = ~clk;
  cache_report_serializer #(.REPORT_PERIOD(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .report_req(report_req),
    .icache_hit_cnt(cnt[1]), .icache_miss_cnt(cnt[2]), .icache_request_cnt(cnt[0]),
    .dcache_hit_cnt(cnt[5]), .dcache_miss_cnt(cnt[6]), .dcache_request_cnt(cnt[4]),
    .icache_fill_lat_cnt(cnt[3]), .dcache_fill_lat_cnt(cnt[7]),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_seq(frame_seq), .dropped_cnt(dropped_cnt)
  );
  cache_report_serializer #(.REPORT_PERIOD(10)) dut_p (
    .clk(clk), .rst_n(rst_n), .enable(enable_p), .report_req(1'b0),
    .icache_hit_cnt(cnt[1]), .icache_miss_cnt(cnt[2]), .icache_request_cnt(cnt[0]),
    .dcache_hit_cnt(cnt[5]), .dcache_miss_cnt(cnt[6]), .dcache_request_cnt(cnt[4]),
    .icache_fill_lat_cnt(cnt[3]), .dcache_fill_lat_cnt(cnt[7]),
    .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(1'b1),
    .busy(busy_p), .frame_seq(frame_seq_p), .dropped_cnt(dropped_cnt_p)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic push_frame(input logic [7:0][31:0] cv);
    logic [7:0] s, b;
    s = 8'(model_seq + 1);
    sbq.push_back(8'hA5);
    sbq.push_back(8'h5A);
    sbq.push_back(s);
    for (int i = 0; i < 8; i++)
      for (int k = 3; k >= 0; k--) begin
        b = cv[i][8*k +: 8];
        sbq.push_back(b);
        s += b;
      end
    sbq.push_back(s);
    model_seq = (model_seq + 1) % 256;
  endtask
  task automatic trig(input logic [7:0][31:0] cv);
    cnt = cv;
    push_frame(cv);
    nx0 = nx;
    report_req = 1;
    @(posedge clk);
    #1 report_req = 0;
    check("valid_after_trig", tx_valid, 1);
    check("busy_after_trig", busy, 1);
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: %0d bytes still expected", sbq.size());
      sbq.delete();
    end
    #1;
  endtask
  task automatic wait_bytes(input int want);
    for (int k = 0; k < 200 && nx - nx0 < want; k++) @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(1)) : 1'b0;
    if (scramble) for (int j = 0; j < 8; j++) cnt[j] = $urandom;
  end
  always @(negedge clk) begin
    if (!rst_n) stall_prev = 0;
    else begin
      if (stall_prev) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, stall_data);
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (tx_valid && tx_ready) begin
        nx++;
        last_byte = tx_data;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %02h with nothing expected", tx_data);
        end else check("byte", tx_data, sbq.pop_front());
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int j = 0; j < 8; j++) begin
      tbl[0].cnt[j] = 32'(j + 1);
      tbl[1].cnt[j] = 32'hFFFFFFFF;
      tbl[2].cnt[j] = 32'h0;
      tbl[3].cnt[j] = 32'h11223344;
      tbl[4].cnt[j] = j == 0 ? 32'h80000000 : 32'h0;
      tbl[5].cnt[j] = 32'(j + 1);
    end
    {tbl[0].rnd, tbl[0].scr, tbl[0].csum} = {1'b0, 1'b0, 8'h25};
    {tbl[1].rnd, tbl[1].scr, tbl[1].csum} = {1'b0, 1'b1, 8'hE2};
    {tbl[2].rnd, tbl[2].scr, tbl[2].csum} = {1'b1, 1'b0, 8'h03};
    {tbl[3].rnd, tbl[3].scr, tbl[3].csum} = {1'b1, 1'b0, 8'h54};
    {tbl[4].rnd, tbl[4].scr, tbl[4].csum} = {1'b1, 1'b1, 8'h85};
    {tbl[5].rnd, tbl[5].scr, tbl[5].csum} = {1'b1, 1'b0, 8'h2A};
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_seq", frame_seq, 0);
    check("rst_dropped", dropped_cnt, 0);
    rst_n = 1;
    enable = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].rnd ? 1 : 0;
      trig(tbl[i].cnt);
      scramble = tbl[i].scr;
      wait_done(400);
      scramble = 0;
      check("csum", last_byte, tbl[i].csum);
      check("byte_count", nx - nx0, FRAME_LEN);
      check("frame_seq", frame_seq, model_seq);
      check("busy_end", busy, 0);
    end
    check("dropped_zero", dropped_cnt, 0);
    mode = 2;
    trig(tbl[0].cnt);
    report_req = 1;
    repeat (300) @(posedge clk);
    #1;
    check("drop_saturate", dropped_cnt, 8'hFF);
    check("busy_stalled", busy, 1);
    mode = 0;
    wait_bytes(10);
    enable = 0;
    wait_done(200);
    check("dis_byte_count", nx - nx0, FRAME_LEN);
    check("dis_frame_seq", frame_seq, model_seq);
    repeat (50) @(posedge clk);
    #1;
    check("dis_busy", busy, 0);
    check("dis_valid", tx_valid, 0);
    check("dis_dropped_kept", dropped_cnt, 8'hFF);
    check("dis_seq_kept", frame_seq, 7);
    report_req = 0;
    enable = 1;
    for (int j = 0; j < 8; j++) c[j] = 32'hDEADBEEF;
    trig(c);
    wait_bytes(20);
    #2 rst_n = 0;
    #1;
    check("arst_valid", tx_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_data", tx_data, 0);
    check("arst_seq", frame_seq, 0);
    check("arst_dropped", dropped_cnt, 0);
    sbq.delete();
    model_seq = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    trig(tbl[0].cnt);
    wait_done(200);
    check("post_rst_csum", last_byte, 8'h25);
    check("post_rst_seq", frame_seq, 1);
    enable_p = 1;
    repeat (9) @(posedge clk);
    #1;
    check("per_before_tick", tx_valid_p, 0);
    @(posedge clk);
    #1;
    check("per_first_valid", tx_valid_p, 1);
    check("per_first_sync", tx_data_p, 8'hA5);
    repeat (36) @(posedge clk);
    #1;
    check("per_frame1_done", tx_valid_p, 0);
    check("per_seq1", frame_seq_p, 1);
    check("per_dropped3", dropped_cnt_p, 3);
    repeat (4) @(posedge clk);
    #1;
    check("per_second_valid", tx_valid_p, 1);
    repeat (10156) @(posedge clk);
    #1;
    check("per_seq255", frame_seq_p, 255);
    repeat (40) @(posedge clk);
    #1;
    check("per_seq_wrap", frame_seq_p, 0);
    check("per_dropped_sat", dropped_cnt_p, 8'hFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
